// File: rtl/float_to_int_if.sv
// Operand/result handshake bundle for the float-to-int converter.
interface float_to_int_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        overflow;
  logic        inexact;

  // Execute stage side: supplies operands, consumes results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, overflow, inexact
  );

  // Converter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, overflow, inexact
  );
endinterface

// File: rtl/float_to_int.sv
// Multi-cycle 16-bit float to 16-bit integer converter (truncate toward zero).
// Magnitude alignment uses a one-bit-per-cycle shifter, so latency depends
// on the exponent.
module float_to_int #(
  parameter int BIAS    = 127,
  parameter bit SAT_NAN = 1'b1
) (
  input logic          clk,
  input logic          reset,
  float_to_int_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLASSIFY = 3'd1,
    SHIFT    = 3'd2,
    NEGATE   = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t r_state, w_state_nx;

  logic [15:0] r_op,   w_op_nx;
  logic [15:0] r_mag,  w_mag_nx;
  logic [3:0]  r_cnt,  w_cnt_nx;
  logic        r_left, w_left_nx;
  logic [15:0] r_out,  w_out_nx;
  logic        r_ovf,  w_ovf_nx;
  logic        r_inx,  w_inx_nx;

  // Operand fields and unbiased exponent decoded from the latched operand.
  logic              w_sign;
  logic [7:0]        w_exp;
  logic [6:0]        w_trail;
  logic signed [9:0] w_unb;
  logic signed [9:0] w_dist;
  logic signed [9:0] w_abs;
  logic [15:0]       w_sat;

  assign w_sign  = r_op[15];
  assign w_exp   = r_op[14:7];
  assign w_trail = r_op[6:0];
  assign w_unb   = $signed({2'b00, w_exp}) - $signed(10'(BIAS));
  assign w_dist  = w_unb - 10'sd7;
  assign w_abs   = w_dist[9] ? -w_dist : w_dist;
  assign w_sat   = w_sign ? 16'h8000 : 16'h7FFF;

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_out;
  assign bus.overflow  = r_ovf;
  assign bus.inexact   = r_inx;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_mag   <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_inx   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_op    <= w_op_nx;
      r_mag   <= w_mag_nx;
      r_cnt   <= w_cnt_nx;
      r_left  <= w_left_nx;
      r_out   <= w_out_nx;
      r_ovf   <= w_ovf_nx;
      r_inx   <= w_inx_nx;
    end
  end

  // Next-state and datapath update for each conversion phase.
  always_comb begin
    w_state_nx = r_state;
    w_op_nx    = r_op;
    w_mag_nx   = r_mag;
    w_cnt_nx   = r_cnt;
    w_left_nx  = r_left;
    w_out_nx   = r_out;
    w_ovf_nx   = r_ovf;
    w_inx_nx   = r_inx;

    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_op_nx    = bus.in_data;
          w_state_nx = CLASSIFY;
        end
      end

      CLASSIFY: begin
        w_state_nx = DONE;
        w_out_nx   = '0;
        w_ovf_nx   = 1'b0;
        w_inx_nx   = 1'b0;
        if (w_exp == 8'd0) begin
          // Denormals flush to zero; a nonzero trail is lost precision.
          w_inx_nx = (w_trail != 7'd0);
        end else if (w_exp == 8'hFF) begin
          w_ovf_nx = 1'b1;
          if (SAT_NAN || (w_trail == 7'd0))
            w_out_nx = w_sat;
        end else if (w_unb < 0) begin
          w_inx_nx = 1'b1;
        end else if (w_unb >= 10'sd15) begin
          // -32768 is the one exponent-15 value that is representable.
          w_out_nx = w_sat;
          w_ovf_nx = !(w_sign && (w_unb == 10'sd15) && (w_trail == 7'd0));
        end else begin
          w_mag_nx   = {8'h00, 1'b1, w_trail};
          w_cnt_nx   = w_abs[3:0];
          w_left_nx  = !w_dist[9];
          w_state_nx = (w_abs[3:0] != 4'd0) ? SHIFT : NEGATE;
        end
      end

      SHIFT: begin
        if (r_left) begin
          w_mag_nx = {r_mag[14:0], 1'b0};
        end else begin
          w_mag_nx = {1'b0, r_mag[15:1]};
          w_inx_nx = r_inx | r_mag[0];
        end
        w_cnt_nx = r_cnt - 4'd1;
        if (r_cnt <= 4'd1)
          w_state_nx = NEGATE;
      end

      NEGATE: begin
        w_out_nx   = w_sign ? (~r_mag + 16'd1) : r_mag;
        w_state_nx = DONE;
      end

      DONE: begin
        if (bus.out_ready)
          w_state_nx = IDLE;
      end

      default: w_state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_float_to_int;

  localparam int BIAS    = 127;
  localparam bit SAT_NAN = 1'b1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  float_to_int_if bus ();

  float_to_int #(.BIAS(BIAS), .SAT_NAN(SAT_NAN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value = (1.m) * 2^E, truncated toward zero, then range-checked.
  task automatic model(input logic [15:0] d, output logic [15:0] r,
                       output logic ov, output logic ix, output int lat);
    int     e, m, ee;
    longint num, q, den, v;
    bit     s;
    s  = d[15];
    e  = int'(d[14:7]);
    m  = int'(d[6:0]);
    ee = e - BIAS;
    r = 16'h0000; ov = 1'b0; ix = 1'b0;
    lat = (ee >= 0 && ee <= 14) ? ((ee > 7 ? ee - 7 : 7 - ee) + 2) : 1;
    if (e == 0) begin
      ix = (m != 0);
      lat = 1;
    end else if (e == 255) begin
      ov = 1'b1;
      lat = 1;
      if (SAT_NAN || m == 0) r = s ? 16'h8000 : 16'h7FFF;
    end else if (ee > 15) begin
      ov = 1'b1;
      r  = s ? 16'h8000 : 16'h7FFF;
    end else begin
      num = 128 + m;
      if (ee >= 7) begin
        q = num * (longint'(1) << (ee - 7));
      end else if (ee < -9) begin
        q = 0; ix = 1'b1;
      end else begin
        den = longint'(1) << (7 - ee);
        q   = num / den;
        ix  = (num % den) != 0;
      end
      v = s ? -q : q;
      if (v > 32767 || v < -32768) begin
        ov = 1'b1; ix = 1'b0;
        r  = s ? 16'h8000 : 16'h7FFF;
      end else begin
        r = v[15:0];
      end
    end
  endtask

  // One conversion: present operand, measure latency, check result, and
  // optionally hold out_ready low for 'hold' cycles with an ignored pulse.
  task automatic do_conv(input logic [15:0] d, input int hold, input string tag);
    logic [15:0] er;
    logic        eo, ei;
    int          el, lat;
    model(d, er, eo, ei, el);
    @(negedge clk);
    check({tag, "_in_ready"}, {15'd0, bus.in_ready}, 16'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"},  16'(lat), 16'(el));
    check({tag, "_data"},     bus.out_data, er);
    check({tag, "_overflow"}, {15'd0, bus.overflow}, {15'd0, eo});
    check({tag, "_inexact"},  {15'd0, bus.inexact}, {15'd0, ei});
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (i == 1);
      bus.in_data  = 16'h3F80;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_data"},  bus.out_data, er);
      check({tag, "_hold_valid"}, {15'd0, bus.out_valid}, 16'd1);
      check({tag, "_hold_ready"}, {15'd0, bus.in_ready}, 16'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_release"}, {14'd0, bus.out_valid, bus.in_ready}, 16'd1);
    bus.out_ready = 1'b0;
  endtask

  logic [15:0] rd;
  logic [7:0]  rexp;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #2;
    check("rst_data",  bus.out_data, 16'h0000);
    check("rst_flags", {14'd0, bus.overflow, bus.inexact}, 16'd0);
    check("rst_hs",    {14'd0, bus.out_valid, bus.in_ready}, 16'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_conv(16'h3F80, 0, "one");
    do_conv(16'h4300, 0, "p128");
    do_conv(16'hC020, 0, "m2p5");
    do_conv(16'h4700, 0, "p32768");
    do_conv(16'hC700, 0, "m32768");
    do_conv(16'h7F80, 0, "pinf");
    do_conv(16'hFF80, 0, "minf");
    do_conv(16'h7FC0, 0, "nan");
    do_conv(16'h3F00, 0, "half");
    do_conv(16'h0005, 0, "denorm");
    do_conv(16'h0000, 0, "zero");
    do_conv(16'h46FF, 0, "max_pos");
    do_conv(16'hC701, 0, "below_min");
    do_conv(16'h4120, 5, "bp10");
    do_conv(16'h4040, 0, "after_bp");

    // Abort during SHIFT: everything returns to reset values immediately.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h3F80;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_data",  bus.out_data, 16'h0000);
    check("abort_flags", {14'd0, bus.overflow, bus.inexact}, 16'd0);
    check("abort_hs",    {14'd0, bus.out_valid, bus.in_ready}, 16'd1);
    @(negedge clk);
    reset = 1'b0;
    do_conv(16'h4300, 0, "post_abort");

    for (int i = 0; i < 150; i++) begin
      rexp = ($urandom_range(0, 99) < 80) ? 8'($urandom_range(115, 145))
                                          : 8'($urandom_range(0, 255));
      rd = {1'($urandom_range(0, 1)), rexp, 7'($urandom_range(0, 127))};
      do_conv(rd, int'($urandom_range(0, 2)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
